// File: rtl/dilithium_adapter_pkg.sv
// -----------------------------------------------------------------------------
// dilithium_adapter_pkg
// Shared types and constants for the Dilithium host-to-core stream adapter:
//   - state_t : adapter FSM states
//   - mode_t  : host mode encoding (keygen / sign / verify / illegal)
//   - DEF_OP_*: default core op codes
//   - CORE_W  : width of the core-side data streams
// -----------------------------------------------------------------------------
package dilithium_adapter_pkg;

    localparam int CORE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_KEYGEN  = 2'd0,
        MODE_SIGN    = 2'd1,
        MODE_VERIFY  = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_t;

    localparam logic [3:0] DEF_OP_KEYGEN = 4'h1;
    localparam logic [3:0] DEF_OP_SIGN   = 4'h2;
    localparam logic [3:0] DEF_OP_VERIFY = 4'h3;

endpackage

// File: rtl/dilithium_stream_adapter_if.sv
// -----------------------------------------------------------------------------
// dilithium_stream_adapter_if
// Host-side streams of the Dilithium stream adapter.
//   valid_i / ready_i / data_i : host -> adapter input stream (BUS_W bits)
//   valid_o / ready_o / data_o : adapter -> host output stream (BUS_W bits)
// Modports:
//   master : the external bus master (drives input stream, accepts output)
//   slave  : the adapter
// -----------------------------------------------------------------------------
interface dilithium_stream_adapter_if #(
    parameter int BUS_W = 64
);
    logic             valid_i;
    logic             ready_i;
    logic [BUS_W-1:0] data_i;
    logic             valid_o;
    logic             ready_o;
    logic [BUS_W-1:0] data_o;

    modport master (
        output valid_i, data_i, ready_o,
        input  ready_i, valid_o, data_o
    );

    modport slave (
        input  valid_i, data_i, ready_o,
        output ready_i, valid_o, data_o
    );
endinterface

// File: rtl/adapter_sync_fifo.sv
// -----------------------------------------------------------------------------
// adapter_sync_fifo
// Synchronous 32-bit FIFO buffering core output words. One word may be pushed
// and up to two words popped per cycle, so a 64-bit packer can drain it at the
// rate the core fills it.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (pointers/count)
//   push, wr_data    write request and word; ignored when full unless a pop
//                    happens in the same cycle
//   pop_cnt          number of words (0..2) removed this cycle; the caller
//                    never pops more than count
//   rd_data0/1       oldest and second-oldest word (combinational read)
//   full, empty      status flags
//   count            number of stored words
// Parameter: DEPTH (power of two, >= 2)
// -----------------------------------------------------------------------------
module adapter_sync_fifo
    import dilithium_adapter_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [CORE_W-1:0] wr_data,
    input  logic [1:0]        pop_cnt,
    output logic [CORE_W-1:0] rd_data0,
    output logic [CORE_W-1:0] rd_data1,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [CORE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    // A push into a full FIFO is fine when a pop frees a slot in the same cycle.
    assign push_ok  = push && (!full || (pop_cnt != 2'd0));
    assign rd_data0 = mem[rd_ptr];
    assign rd_data1 = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr + AW'(pop_cnt);
            count  <= count + CW'(push_ok) - CW'(pop_cnt);
        end
    end

endmodule

// File: rtl/dilithium_stream_adapter.sv
// -----------------------------------------------------------------------------
// dilithium_stream_adapter
// Host-to-core adapter for a Dilithium core. Turns start/mode into a core op
// handshake, width-converts the BUS_W host input stream to the 32-bit core
// input stream, buffers 32-bit core output words in a FIFO and packs them back
// to BUS_W for the host, signals completion and latches the sign reject flag.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start, mode                    op request (sampled in IDLE only)
//   host (slave modport)           host input and output streams
//   done, err                      one-cycle completion / illegal-mode pulses
//   sign_reject                    latched reject flag of the last sign op
//   op_in, op_valid_in, ready_out  core op handshake; ready_out also marks
//                                  core idle (its rising edge in RUN = finished)
//   core_data_in/valid_in/ready_in core input stream (32 bit)
//   core_data_out/valid_out/ready_out core output stream (32 bit)
//   core_reject                    core reject indication
//   cycle_cnt                      busy-cycle counter, present only when the
//                                  macro DILITHIUM_ADAPTER_CYCLE_CNT_EN is defined
// Parameters: BUS_W (32 or 64), OUT_DEPTH (power of two >= 2),
//             OP_KEYGEN, OP_SIGN, OP_VERIFY (core op codes for mode 0/1/2)
// -----------------------------------------------------------------------------
module dilithium_stream_adapter
    import dilithium_adapter_pkg::*;
#(
    parameter int         BUS_W     = 64,
    parameter int         OUT_DEPTH = 8,
    parameter logic [3:0] OP_KEYGEN = DEF_OP_KEYGEN,
    parameter logic [3:0] OP_SIGN   = DEF_OP_SIGN,
    parameter logic [3:0] OP_VERIFY = DEF_OP_VERIFY
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          mode,
    dilithium_stream_adapter_if.slave host,
    output logic                done,
    output logic                err,
    output logic                sign_reject,
    output logic [3:0]          op_in,
    output logic                op_valid_in,
    input  logic                ready_out,
    output logic [CORE_W-1:0]   core_data_in,
    output logic                core_valid_in,
    input  logic                core_ready_in,
    input  logic [CORE_W-1:0]   core_data_out,
    input  logic                core_valid_out,
    output logic                core_ready_out,
    input  logic                core_reject
`ifdef DILITHIUM_ADAPTER_CYCLE_CNT_EN
    ,
    output logic [31:0]         cycle_cnt
`endif
);

    localparam int CW = $clog2(OUT_DEPTH) + 1;

    if (BUS_W != 32 && BUS_W != 64) begin : g_bad_bus_w
        $error("dilithium_stream_adapter: BUS_W must be 32 or 64");
    end
    if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dilithium_stream_adapter: OUT_DEPTH must be a power of two >= 2");
    end

    state_t            state;
    logic              ready_out_q;
    logic              is_sign;
    logic              in_run;

    logic              fifo_push;
    logic [1:0]        pop_cnt;
    logic [CORE_W-1:0] rd_data0;
    logic [CORE_W-1:0] rd_data1;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    logic              out_valid;
    logic [BUS_W-1:0]  out_data;
    logic              out_free;

    function automatic logic [3:0] op_code(input mode_t m);
        case (m)
            MODE_SIGN:   return OP_SIGN;
            MODE_VERIFY: return OP_VERIFY;
            default:     return OP_KEYGEN;
        endcase
    endfunction

    assign in_run         = (state == ST_RUN);
    assign core_ready_out = ((state == ST_RUN) || (state == ST_FLUSH)) && !fifo_full;
    assign fifo_push      = core_valid_out && core_ready_out;
    assign out_free       = !out_valid || host.ready_o;
    assign host.valid_o   = out_valid;
    assign host.data_o    = out_data;

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ready_out_q <= 1'b0;
            is_sign     <= 1'b0;
            op_in       <= 4'h0;
            op_valid_in <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            sign_reject <= 1'b0;
`ifdef DILITHIUM_ADAPTER_CYCLE_CNT_EN
            cycle_cnt   <= 32'h0;
`endif
        end else begin
            done        <= 1'b0;
            err         <= 1'b0;
            ready_out_q <= ready_out;

`ifdef DILITHIUM_ADAPTER_CYCLE_CNT_EN
            if (state != ST_IDLE && cycle_cnt != 32'hFFFF_FFFF) begin
                cycle_cnt <= cycle_cnt + 32'h1;
            end
`endif

            if (is_sign && core_reject && state != ST_IDLE) begin
                sign_reject <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (mode_t'(mode) == MODE_ILLEGAL) begin
                            err <= 1'b1;
                        end else begin
                            op_in       <= op_code(mode_t'(mode));
                            op_valid_in <= 1'b1;
                            is_sign     <= (mode_t'(mode) == MODE_SIGN);
                            sign_reject <= 1'b0;
                            state       <= ST_ISSUE;
`ifdef DILITHIUM_ADAPTER_CYCLE_CNT_EN
                            cycle_cnt   <= 32'h0;
`endif
                        end
                    end
                end
                ST_ISSUE: begin
                    if (ready_out) begin
                        op_valid_in <= 1'b0;
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // ready_out was high during the op handshake, so only a
                    // fresh low-to-high transition means the core finished.
                    if (ready_out && !ready_out_q) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty && !out_valid) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Input gearbox: host words -> 32-bit core words
    // ---------------------------------------------------------------------
    if (BUS_W == 64) begin : g_in64
        logic [2*CORE_W-1:0] hold_data;
        logic                hold_full;
        logic                hold_hi;

        // The holding register frees in the cycle its high half is taken,
        // letting the next host word in without a bubble.
        assign host.ready_i = in_run &&
                              (!hold_full || (hold_hi && core_valid_in && core_ready_in));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_data     <= '0;
                hold_full     <= 1'b0;
                hold_hi       <= 1'b0;
                core_data_in  <= '0;
                core_valid_in <= 1'b0;
            end else if (host.valid_i && host.ready_i) begin
                hold_data     <= host.data_i;
                hold_full     <= 1'b1;
                hold_hi       <= 1'b0;
                core_data_in  <= host.data_i[CORE_W-1:0];
                core_valid_in <= 1'b1;
            end else if (core_valid_in && core_ready_in) begin
                if (!hold_hi) begin
                    core_data_in <= hold_data[2*CORE_W-1:CORE_W];
                    hold_hi      <= 1'b1;
                end else begin
                    core_valid_in <= 1'b0;
                    hold_full     <= 1'b0;
                    hold_hi       <= 1'b0;
                end
            end
        end
    end else begin : g_in32
        assign host.ready_i = in_run && (!core_valid_in || core_ready_in);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                core_data_in  <= '0;
                core_valid_in <= 1'b0;
            end else if (host.valid_i && host.ready_i) begin
                core_data_in  <= host.data_i;
                core_valid_in <= 1'b1;
            end else if (core_valid_in && core_ready_in) begin
                core_valid_in <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output buffer
    // ---------------------------------------------------------------------
    adapter_sync_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .wr_data  (core_data_out),
        .pop_cnt  (pop_cnt),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // ---------------------------------------------------------------------
    // Output packer: FIFO words -> host words, first word in the low half
    // ---------------------------------------------------------------------
    if (BUS_W == 64) begin : g_out64
        // Pairs are popped only when both halves are present; a lone word is
        // released zero-padded once the core has finished.
        always_comb begin
            pop_cnt = 2'd0;
            if (out_free) begin
                if (fifo_count >= CW'(2)) begin
                    pop_cnt = 2'd2;
                end else if (state == ST_FLUSH && fifo_count == CW'(1)) begin
                    pop_cnt = 2'd1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end else if (pop_cnt == 2'd2) begin
                out_valid <= 1'b1;
                out_data  <= {rd_data1, rd_data0};
            end else if (pop_cnt == 2'd1) begin
                out_valid <= 1'b1;
                out_data  <= {{CORE_W{1'b0}}, rd_data0};
            end else if (out_free) begin
                out_valid <= 1'b0;
            end
        end
    end else begin : g_out32
        always_comb begin
            pop_cnt = 2'd0;
            if (out_free && !fifo_empty) begin
                pop_cnt = 2'd1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end else if (pop_cnt == 2'd1) begin
                out_valid <= 1'b1;
                out_data  <= rd_data0;
            end else if (out_free) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dilithium_stream_adapter.sv
// -----------------------------------------------------------------------------
// tb_dilithium_stream_adapter
// Directed self-checking bench for dilithium_stream_adapter (BUS_W=64,
// OUT_DEPTH=8). A mode table drives the op handshake / err behaviour; hand
// sequences cover the gearbox, packing, FIFO stall, reject flag and reset abort.
// -----------------------------------------------------------------------------
module tb_dilithium_stream_adapter;
    import dilithium_adapter_pkg::*;

    localparam int BUS_W     = 64;
    localparam int OUT_DEPTH = 8;

    typedef struct {
        logic [1:0] mode;
        logic       exp_err;
        logic       exp_opv;
        logic [3:0] exp_op;
    } mode_vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        done, err, sign_reject;
    logic [3:0]  op_in;
    logic        op_valid_in;
    logic        ready_out = 1'b0;
    logic [31:0] core_data_in;
    logic        core_valid_in;
    logic        core_ready_in = 1'b1;
    logic [31:0] core_data_out = 32'h0;
    logic        core_valid_out = 1'b0;
    logic        core_ready_out;
    logic        core_reject = 1'b0;
`ifdef DILITHIUM_ADAPTER_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;
`endif

    dilithium_stream_adapter_if #(.BUS_W(BUS_W)) hif ();

    dilithium_stream_adapter #(
        .BUS_W     (BUS_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .mode           (mode),
        .host           (hif),
        .done           (done),
        .err            (err),
        .sign_reject    (sign_reject),
        .op_in          (op_in),
        .op_valid_in    (op_valid_in),
        .ready_out      (ready_out),
        .core_data_in   (core_data_in),
        .core_valid_in  (core_valid_in),
        .core_ready_in  (core_ready_in),
        .core_data_out  (core_data_out),
        .core_valid_out (core_valid_out),
        .core_ready_out (core_ready_out),
        .core_reject    (core_reject)
`ifdef DILITHIUM_ADAPTER_CYCLE_CNT_EN
        ,
        .cycle_cnt      (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    logic [63:0] got[$];
    logic [31:0] cin[$];

    // Observe handshakes mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        if (hif.valid_o && hif.ready_o) got.push_back(hif.data_o);
        if (core_valid_in && core_ready_in) cin.push_back(core_data_in);
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [31:0] cin_at(input int i);
        if (i < cin.size()) return cin[i];
        return 32'hDEAD_DEAD;
    endfunction

    // Offer one core output word; returns ok=1 once the adapter took it.
    task automatic emit(input logic [31:0] w, output bit ok);
        ok = 1'b0;
        core_valid_out = 1'b1;
        core_data_out  = w;
        for (int k = 0; k < 8; k++) begin
            if (core_ready_out) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        core_valid_out = 1'b0;
    endtask

    // Start an op and complete the handshake; leaves the core busy (ready_out=0).
    task automatic begin_op(input logic [1:0] m);
        ready_out = 1'b0;
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        tick();
    endtask

    // Core returns to idle; expect exactly one done pulse.
    task automatic finish_op(input string name);
        int d0;
        d0 = done_cnt;
        ready_out = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (done) break;
        end
        tick();
        tick();
        check({"done_once_", name}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        mode_vec_t   mvec[4];
        logic [63:0] pk_exp[3];
        logic [63:0] stall_exp[6];
        bit          ok;
        int          acc;
        int          k;
        int          d0;

        mvec[0] = '{mode: 2'd3, exp_err: 1'b1, exp_opv: 1'b0, exp_op: 4'h0};
        mvec[1] = '{mode: 2'd0, exp_err: 1'b0, exp_opv: 1'b1, exp_op: 4'h1};
        mvec[2] = '{mode: 2'd1, exp_err: 1'b0, exp_opv: 1'b1, exp_op: 4'h2};
        mvec[3] = '{mode: 2'd2, exp_err: 1'b0, exp_opv: 1'b1, exp_op: 4'h3};

        pk_exp[0] = 64'h0000_0002_0000_0001;
        pk_exp[1] = 64'h0000_0004_0000_0003;
        pk_exp[2] = 64'h0000_0000_0000_0005;

        stall_exp[0] = 64'h0000_0002_0000_0001;
        stall_exp[1] = 64'h0000_0004_0000_0003;
        stall_exp[2] = 64'h0000_0006_0000_0005;
        stall_exp[3] = 64'h0000_0008_0000_0007;
        stall_exp[4] = 64'h0000_000A_0000_0009;
        stall_exp[5] = 64'h0000_0000_0000_000B;

        hif.valid_i = 1'b0;
        hif.data_i  = '0;
        hif.ready_o = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", 64'({op_valid_in, core_valid_in, core_ready_out, done, err,
                                 sign_reject, hif.ready_i, hif.valid_o}), 64'h0);
        check("reset_data_o", hif.data_o, 64'h0);
        check("reset_op_in", 64'(op_in), 64'h0);
        rst_n = 1'b1;
        tick();

        // Mode table: err pulse, op handshake, op_in held until ready_out
        for (int i = 0; i < 4; i++) begin
            ready_out = 1'b0;
            start = 1'b1;
            mode  = mvec[i].mode;
            tick();
            start = 1'b0;
            check($sformatf("err_m%0d", i), 64'(err), 64'(mvec[i].exp_err));
            check($sformatf("opv_m%0d", i), 64'(op_valid_in), 64'(mvec[i].exp_opv));
            tick();
            check($sformatf("err_clear_m%0d", i), 64'(err), 64'h0);
            check($sformatf("opv_hold_m%0d", i), 64'(op_valid_in), 64'(mvec[i].exp_opv));
            if (mvec[i].exp_opv) begin
                check($sformatf("op_in_m%0d", i), 64'(op_in), 64'(mvec[i].exp_op));
                ready_out = 1'b1;
                tick();
                check($sformatf("opv_drop_m%0d", i), 64'(op_valid_in), 64'h0);
                ready_out = 1'b0;
                tick();
                finish_op($sformatf("m%0d", i));
            end
        end

        // Sign op: op_in held over a stalled handshake, gearbox, packing
        got.delete();
        cin.delete();
        ready_out = 1'b0;
        start = 1'b1;
        mode  = 2'd1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("op_hold_%0d", i), 64'({op_valid_in, op_in}), 64'h12);
        end
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        tick();
        hif.valid_i = 1'b1;
        hif.data_i  = 64'h0000_0002_0000_0001;
        check("ready_i_run", 64'(hif.ready_i), 64'h1);
        tick();
        hif.data_i = 64'h0000_0004_0000_0003;
        k = 0;
        while (!hif.ready_i && k < 6) begin
            tick();
            k++;
        end
        tick();
        hif.valid_i = 1'b0;
        check("in_spacing", 64'(k), 64'd1);
        repeat (3) tick();
        check("cin_count", 64'(cin.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("cin_%0d", i), 64'(cin_at(i)), 64'(i + 1));
        acc = 0;
        for (int w = 1; w <= 5; w++) begin
            emit(32'(w), ok);
            acc += int'(ok);
        end
        check("emit5_accepted", 64'(acc), 64'd5);
        finish_op("sign_pack");
        check("pack_count", 64'(got.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("pack_%0d", i), got_at(i), pk_exp[i]);
        check("no_reject", 64'(sign_reject), 64'h0);

        // FIFO full with host stalled
        got.delete();
        hif.ready_o = 1'b0;
        begin_op(2'd0);
        acc = 0;
        for (int w = 1; w <= 10; w++) begin
            emit(32'(w), ok);
            acc += int'(ok);
        end
        check("stall_accepted", 64'(acc), 64'd10);
        check("core_ready_full", 64'(core_ready_out), 64'h0);
        core_valid_out = 1'b1;
        core_data_out  = 32'd11;
        repeat (4) tick();
        check("core_ready_stall", 64'(core_ready_out), 64'h0);
        check("stall_no_output", 64'(got.size()), 64'd0);
        hif.ready_o = 1'b1;
        emit(32'd11, ok);
        check("stall_word11", 64'(ok), 64'h1);
        finish_op("stall");
        check("stall_count", 64'(got.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("stall_%0d", i), got_at(i), stall_exp[i]);

        // Reject latching
        begin_op(2'd1);
        core_reject = 1'b1;
        tick();
        core_reject = 1'b0;
        finish_op("reject");
        check("reject_latched", 64'(sign_reject), 64'h1);
        ready_out = 1'b0;
        start = 1'b1;
        mode  = 2'd0;
        tick();
        start = 1'b0;
        check("reject_cleared", 64'(sign_reject), 64'h0);
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        tick();
        core_reject = 1'b1;
        start = 1'b1;
        mode  = 2'd3;
        tick();
        core_reject = 1'b0;
        start = 1'b0;
        check("busy_start_no_err", 64'(err), 64'h0);
        check("busy_start_no_op", 64'(op_valid_in), 64'h0);
        finish_op("keygen_reject");
        check("keygen_no_reject", 64'(sign_reject), 64'h0);

        // Reset mid-RUN aborts without done
        hif.ready_o = 1'b0;
        begin_op(2'd0);
        for (int w = 1; w <= 3; w++) emit(32'(w), ok);
        d0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ctrl", 64'({op_valid_in, core_valid_in, core_ready_out, done, err,
                                 sign_reject, hif.ready_i, hif.valid_o}), 64'h0);
        check("abort_data_o", hif.data_o, 64'h0);
        check("abort_op_in", 64'(op_in), 64'h0);
        tick();
        check("abort_ctrl_edge", 64'({core_ready_out, done, hif.valid_o}), 64'h0);
        rst_n = 1'b1;
        tick();
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        got.delete();
        hif.ready_o = 1'b1;
        begin_op(2'd0);
        emit(32'h7, ok);
        emit(32'h8, ok);
        finish_op("after_reset");
        check("after_reset_count", 64'(got.size()), 64'd1);
        check("after_reset_word", got_at(0), 64'h0000_0008_0000_0007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
